// File: rtl/rc_channel_decoder_if.sv
// rtl/rc_channel_decoder_if.sv - receiver pin and decoded-offset bundle for one RC channel
interface rc_channel_decoder_if;
  logic       pwm_in;
  logic [7:0] offset;
  logic       valid;
  logic       signal_lost;

  // Receiver side: drives the raw PWM pin and consumes the decoded channel
  modport master (
    output pwm_in,
    input  offset,
    input  valid,
    input  signal_lost
  );

  // Decoder side
  modport slave (
    input  pwm_in,
    output offset,
    output valid,
    output signal_lost
  );
endinterface

// File: rtl/rc_channel_decoder.sv
// rtl/rc_channel_decoder.sv - RC PWM channel width decoder with pulse rejection and failsafe
module rc_channel_decoder #(
  parameter int unsigned CYCLES_PER_US  = 50,
  parameter int unsigned MIN_US         = 1000,
  parameter int unsigned STEP_US        = 10,
  parameter int unsigned MAX_VALUE      = 100,
  parameter int unsigned MIN_VALID_US   = 800,
  parameter int unsigned MAX_VALID_US   = 2200,
  parameter int unsigned TIMEOUT_US     = 25000,
  parameter int unsigned FAILSAFE_VALUE = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  rc_channel_decoder_if.slave ch
);

  localparam int unsigned PRESC_W = (CYCLES_PER_US > 1) ? $clog2(CYCLES_PER_US) : 1;
  localparam int unsigned STEP_W  = (STEP_US > 1) ? $clog2(STEP_US) : 1;
  localparam int unsigned TO_W    = $clog2(TIMEOUT_US + 1);

  localparam logic [PRESC_W-1:0] PRESC_LAST   = PRESC_W'(CYCLES_PER_US - 1);
  localparam logic [STEP_W-1:0]  STEP_LAST    = STEP_W'(STEP_US - 1);
  localparam logic [TO_W-1:0]    TO_LIMIT     = TO_W'(TIMEOUT_US);
  localparam logic [11:0]        WIDTH_SAT    = 12'hFFF;
  localparam logic [11:0]        MIN_US_W     = 12'(MIN_US);
  localparam logic [11:0]        MIN_VALID_W  = 12'(MIN_VALID_US);
  localparam logic [11:0]        MAX_VALID_W  = 12'(MAX_VALID_US);
  localparam logic [7:0]         MAX_VAL_W    = 8'(MAX_VALUE);
  localparam logic [7:0]         FAILSAFE_W   = 8'(FAILSAFE_VALUE);

  typedef enum logic [0:0] {
    WAIT_RISE = 1'b0,
    MEASURE   = 1'b1
  } state_t;

  // Pin synchronizer and edge history; bit 0 = s1, bit 1 = s2, bit 2 = s3
  logic [2:0]         sync_q;
  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] presc_d;
  state_t             state_q;
  logic [11:0]        width_q;
  logic [STEP_W-1:0]  step_q;
  logic [7:0]         raw_q;
  logic [TO_W-1:0]    to_q;
  logic [TO_W-1:0]    to_d;
  logic [7:0]         offset_q;
  logic               valid_q;
  logic               lost_q;

  logic               rise;
  logic               fall;
  logic               tick;
  logic [11:0]        width_d;
  logic [STEP_W-1:0]  step_d;
  logic [7:0]         raw_d;
  logic               in_range;
  logic               accept;
  logic               timeout_hit;

  assign rise = sync_q[1] & ~sync_q[2];
  assign fall = ~sync_q[1] & sync_q[2];
  assign tick = (presc_q == PRESC_LAST);

  // Resync the asynchronous pin; reset high so a pin already high is not a rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[1:0], ch.pwm_in};
    end
  end

  // Microsecond prescaler, phase-aligned to each rising edge so widths start on a whole count
  always_comb begin
    presc_d = presc_q + PRESC_W'(1);
    if (rise || tick) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // Width, step and raw offset as they stand after this cycle's tick, so a fall coinciding
  // with a tick still counts that last microsecond; raw tracks (w - MIN_US) / STEP_US
  always_comb begin
    width_d = width_q;
    step_d  = step_q;
    raw_d   = raw_q;
    if (tick) begin
      if (width_q != WIDTH_SAT) begin
        width_d = width_q + 12'd1;
      end
      if (width_q >= MIN_US_W) begin
        if (step_q == STEP_LAST) begin
          step_d = '0;
          if (raw_q < MAX_VAL_W) begin
            raw_d = raw_q + 8'd1;
          end
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
    end
  end

  // Pulse acceptance and timeout decisions; accept takes priority over failsafe entry
  always_comb begin
    in_range    = (width_d >= MIN_VALID_W) && (width_d <= MAX_VALID_W);
    accept      = (state_q == MEASURE) && fall && in_range;
    timeout_hit = (to_q == TO_LIMIT) && !lost_q;
    to_d        = to_q;
    if (accept) begin
      to_d = '0;
    end else if (tick && (to_q != TO_LIMIT)) begin
      to_d = to_q + TO_W'(1);
    end
  end

  // Measurement FSM with the registered channel outputs and the timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= WAIT_RISE;
      width_q  <= '0;
      step_q   <= '0;
      raw_q    <= '0;
      to_q     <= '0;
      offset_q <= FAILSAFE_W;
      valid_q  <= 1'b0;
      lost_q   <= 1'b1;
    end else begin
      valid_q <= 1'b0;
      to_q    <= to_d;
      case (state_q)
        WAIT_RISE: begin
          if (rise) begin
            state_q <= MEASURE;
            width_q <= '0;
            step_q  <= '0;
            raw_q   <= '0;
          end
        end
        MEASURE: begin
          width_q <= width_d;
          step_q  <= step_d;
          raw_q   <= raw_d;
          if (fall) begin
            state_q <= WAIT_RISE;
          end
        end
        default: begin
          state_q <= WAIT_RISE;
        end
      endcase
      if (accept) begin
        offset_q <= raw_d;
        valid_q  <= 1'b1;
        lost_q   <= 1'b0;
      end else if (timeout_hit) begin
        offset_q <= FAILSAFE_W;
        valid_q  <= 1'b1;
        lost_q   <= 1'b1;
      end
    end
  end

  assign ch.offset      = offset_q;
  assign ch.valid       = valid_q;
  assign ch.signal_lost = lost_q;

endmodule

// File: tb/tb_rc_channel_decoder.sv
// tb/tb_rc_channel_decoder.sv - directed and random pulse bench for rc_channel_decoder
module tb_rc_channel_decoder;
  localparam int CPU    = 4;
  localparam int TO_CYC = 25000 * CPU + 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rc_channel_decoder_if ch();

  rc_channel_decoder #(.CYCLES_PER_US(CPU)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ch   (ch)
  );

  int     n_checks = 0;
  int     n_fail   = 0;
  int     vcnt     = 0;
  int     exp_vcnt = 0;
  int     exp_offset = 0;
  bit     exp_lost = 1'b1;
  longint now = 0;
  longint last_acc = 0;

  // Count valid strobes, one per high sample
  always @(negedge clk) begin
    if (ch.valid === 1'b1) vcnt <= vcnt + 1;
  end

  function automatic int ref_offset(input int w);
    int v;
    if (w < 1000) return 0;
    v = (w - 1000) / 10;
    return (v > 100) ? 100 : v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " strobes"}, vcnt, exp_vcnt);
    check({tag, " offset"}, 32'(ch.offset), exp_offset);
    check({tag, " signal_lost"}, 32'(ch.signal_lost), 32'(exp_lost));
  endtask

  // Advance n cycles; the model enters failsafe once a full timeout passes after the last accept
  task automatic hold(input longint n);
    for (longint i = 0; i < n; i++) begin
      @(negedge clk);
      now++;
      if (!exp_lost && (now - last_acc) == TO_CYC) begin
        exp_lost   = 1'b1;
        exp_offset = 0;
        exp_vcnt++;
      end
    end
  endtask

  task automatic pulse(input int w_us, input int gap_cyc, input bit measured);
    ch.pwm_in = 1'b1;
    hold(longint'(w_us) * CPU);
    ch.pwm_in = 1'b0;
    if (measured && w_us >= 800 && w_us <= 2200) begin
      exp_offset = ref_offset(w_us);
      exp_lost   = 1'b0;
      exp_vcnt++;
      last_acc   = now;
    end
    hold(gap_cyc);
  endtask

  int widths[8] = '{1000, 1019, 2000, 2150, 800, 2200, 799, 2201};

  initial begin
    int w;
    int g;
    ch.pwm_in = 1'b1;
    rst_n = 1'b0;
    hold(5);
    check("reset offset", 32'(ch.offset), 0);
    check("reset valid", 32'(ch.valid), 0);
    check("reset signal_lost", 32'(ch.signal_lost), 1);
    rst_n = 1'b1;

    // Pin high at reset release: the partial pulse must be ignored
    hold(500 * CPU);
    ch.pwm_in = 1'b0;
    hold(400);
    check_all("partial pulse");

    pulse(1500, 40, 1'b1);
    check_all("first 1500us");

    foreach (widths[i]) begin
      pulse(widths[i], 40, 1'b1);
      check_all($sformatf("width %0d", widths[i]));
    end

    pulse(1500, 40, 1'b1);
    pulse(700, 40, 1'b1);
    check_all("reject 700");
    pulse(2300, 40, 1'b1);
    check_all("reject 2300");

    // Back-to-back pulses with a single low clock
    pulse(1500, 1, 1'b1);
    pulse(1200, 40, 1'b1);
    check_all("back to back");

    // Silent receiver: failsafe once, no repeats, then recovery
    pulse(1500, 0, 1'b1);
    hold(24990 * CPU);
    check_all("before timeout");
    hold(20 * CPU);
    check_all("timeout entry");
    hold(1000 * CPU);
    check_all("timeout hold");
    pulse(1200, 40, 1'b1);
    check_all("recover 1200");

    // Pin stuck high after an accepted pulse
    pulse(1500, 400, 1'b1);
    ch.pwm_in = 1'b1;
    hold(24990 * CPU - 400);
    check_all("stuck before timeout");
    hold(20 * CPU);
    check_all("stuck timeout entry");
    hold(30000 * CPU - (24990 * CPU - 400) - 20 * CPU);
    ch.pwm_in = 1'b0;
    hold(40);
    check_all("stuck fall rejected");

    // Reset 600us into a pulse
    pulse(1500, 40, 1'b1);
    check_all("pre-reset pulse");
    ch.pwm_in = 1'b1;
    hold(600 * CPU);
    rst_n = 1'b0;
    #1;
    exp_offset = 0;
    exp_lost   = 1'b1;
    check("mid reset offset", 32'(ch.offset), 0);
    check("mid reset valid", 32'(ch.valid), 0);
    check("mid reset signal_lost", 32'(ch.signal_lost), 1);
    hold(10);
    rst_n = 1'b1;
    hold(900 * CPU);
    ch.pwm_in = 1'b0;
    hold(400);
    check_all("fall after reset");
    pulse(1800, 40, 1'b1);
    check_all("post reset 1800");

    // Random widths across and beyond the valid window
    for (int k = 0; k < 8; k++) begin
      w = int'($urandom_range(2300, 700));
      g = int'($urandom_range(200, 20));
      pulse(w, g, 1'b1);
      check_all($sformatf("random %0d", w));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
